committed_store_buffer: RTL and testbench
=========================================

// Module: committed_store_buffer
// PURPOSE
//  Holds architecturally committed stores after the store queue retires them at ROB commit.
//  Drains them in order to the L1 over a valid/ready request channel, with up to
//  MAX_OUTSTANDING requests in flight; in-order acks free the entries.
//  Supports byte/half/word(/dword) stores with byte masks and optional same-word coalescing.
//  Gives the load pipeline a combinational byte-granular forwarding lookup.
//  Flushes never touch this block: its contents are architectural.
// PARAMETERS
//  XLEN             32  data/address width; 32 or 64
//  DEPTH            8   entries; power of two, >=2
//  ROB_TAG_WIDTH    5   width of stored ROB tag (debug/trace only)
//  MAX_OUTSTANDING  2   issued-but-unacked request limit, 1..DEPTH
//  COALESCE         1   1 = merge a commit into the youngest pending entry when word addresses match
// PORTS
//  clk               in   1              clock
//  reset             in   1              synchronous, active-high
//  commit_valid      in   1              committed store offered
//  commit_ready      out  1              = !full; transfer when valid&&ready
//  commit_address    in   XLEN           byte address
//  commit_data       in   XLEN           store data, LSB-aligned
//  commit_size       in   2              0=B 1=H 2=W 3=D (D legal only if XLEN=64)
//  commit_rob_tag    in   ROB_TAG_WIDTH  stored with the entry
//  misaligned        out  1              registered 1-cycle pulse: last commit was dropped
//  mem_req_valid     out  1              request offered at issue pointer
//  mem_req_ready     in   1              L1 accepts the request
//  mem_req_address   out  XLEN           word-aligned (low OFF=$clog2(XLEN/8) bits zero)
//  mem_req_data      out  XLEN           data shifted to byte lane: data << 8*addr[OFF-1:0]
//  mem_req_byte_mask out  XLEN/8         bytes written
//  mem_resp_valid    in   1              ack for oldest outstanding request (in order)
//  fwd_valid         in   1              load lookup
//  fwd_address       in   XLEN           load byte address
//  fwd_size          in   2              load size, same encoding
//  fwd_hit           out  1              every requested byte is covered by the buffer
//  fwd_data          out  XLEN           forwarded bytes, LSB-aligned, zero above size
//  fwd_conflict      out  1              some, not all, requested bytes covered: load must replay
//  count             out  $clog2(DEPTH)+1  occupied entries (PENDING+ISSUED)
//  empty             out  1              count==0
// BEHAVIOUR
//  Reset: all entries FREE; head=issue=tail=0; count=0, empty=1, commit_ready=1,
//   mem_req_valid=0, misaligned=0, fwd_hit=0, fwd_conflict=0, fwd_data=0.
//  Entry state per slot: FREE -> PENDING (on write) -> ISSUED (on mem_req_valid&&ready)
//   -> FREE (on mem_resp_valid at head). Pointers carry one wrap bit;
//   full when ptrs equal and wrap bits differ.
//  Commit transfer, taken at the clock edge:
//   Misaligned (H with a[0]!=0, W with a[1:0]!=0, D with a[2:0]!=0, or D when XLEN=32):
//    not written, misaligned=1 next cycle. commit_ready is unaffected.
//   Coalesce: COALESCE=1, youngest entry (tail-1) PENDING, that entry != issue pointer,
//    and word addresses equal. New bytes overwrite the data lanes; mask |= new mask;
//    rob_tag updated; tail unchanged.
//   Otherwise: write at tail, tail++.
//  Issue:
//   mem_req_valid = entry[issue] PENDING && (issue-head) < MAX_OUTSTANDING.
//   Outputs come straight from entry storage, so they are stable while valid && !ready.
//   An offered entry is never coalesced into.
//  Ack: mem_resp_valid frees head, head++. mem_resp_valid with no ISSUED entry is
//   ignored (covers late acks after reset).
//  Simultaneous events:
//   Commit, issue and ack may all occur in one cycle; count = count + wr - ack.
//   Commit while full with a coalesce match is still refused (ready depends on full only).
//  Forwarding:
//   Combinational from registered state only; a commit in the same cycle is not visible.
//   Per requested byte, source = youngest PENDING/ISSUED entry whose word address matches
//    and whose mask covers that byte.
//   fwd_hit = fwd_valid && all bytes sourced. fwd_conflict = fwd_valid && some-but-not-all
//    sourced. fwd_data is valid only when fwd_hit, else 0.
//  Reset mid-operation: all state cleared in one cycle; in-flight L1 requests are abandoned.
// TESTING
//  1 reset; commit W 0x100=0xDEADBEEF; mem_req_ready=1
//    -> next cycle req addr 0x100, data 0xDEADBEEF, mask 4'b1111; ack -> empty=1
//  2 commit B 0x203=0xAA then B 0x201=0x55 while entry 0 is not at issue pointer (COALESCE=1)
//    -> single req addr 0x200, mask 4'b1010, data 0xAA005500
//  3 fill 8 entries with mem_req_ready=0 -> commit_ready=0, count=8; raise ready with no acks
//    -> exactly 2 requests accepted, valid then drops; ack one -> third issues
//  4 pending W 0x300=0x11223344; fwd W 0x300 -> hit, data 0x11223344; fwd H 0x302
//    -> hit, data 0x1122; fwd W 0x304 -> hit=0, conflict=0
//  5 pending B 0x401=0x77; fwd W 0x400 -> conflict=1, hit=0;
//    commit H 0x401 -> dropped, misaligned pulses 1 cycle, count unchanged
//  6 reset asserted with 2 ISSUED + 3 PENDING -> next cycle empty=1, mem_req_valid=0;
//    stray mem_resp_valid ignored, count stays 0

Source files
------------

// File: rtl/committed_store_buffer_if.sv
// committed_store_buffer_if: commit, L1 request, forwarding and status signals of the store buffer
interface committed_store_buffer_if #(
    parameter int XLEN          = 32,
    parameter int ROB_TAG_WIDTH = 5,
    parameter int DEPTH         = 8
);
    localparam int NB = XLEN / 8;
    localparam int CW = $clog2(DEPTH) + 1;
    logic                     commit_valid;
    logic                     commit_ready;
    logic [XLEN-1:0]          commit_address;
    logic [XLEN-1:0]          commit_data;
    logic [1:0]               commit_size;
    logic [ROB_TAG_WIDTH-1:0] commit_rob_tag;
    logic                     misaligned;
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic [XLEN-1:0]          mem_req_address;
    logic [XLEN-1:0]          mem_req_data;
    logic [NB-1:0]            mem_req_byte_mask;
    logic                     mem_resp_valid;
    logic                     fwd_valid;
    logic [XLEN-1:0]          fwd_address;
    logic [1:0]               fwd_size;
    logic                     fwd_hit;
    logic [XLEN-1:0]          fwd_data;
    logic                     fwd_conflict;
    logic [CW-1:0]            count;
    logic                     empty;
    logic [ROB_TAG_WIDTH-1:0] trace_rob_tag;
    modport slave (
        input  commit_valid, commit_address, commit_data, commit_size, commit_rob_tag,
               mem_req_ready, mem_resp_valid, fwd_valid, fwd_address, fwd_size,
        output commit_ready, misaligned, mem_req_valid, mem_req_address, mem_req_data,
               mem_req_byte_mask, fwd_hit, fwd_data, fwd_conflict, count, empty, trace_rob_tag
    );
    modport master (
        output commit_valid, commit_address, commit_data, commit_size, commit_rob_tag,
               mem_req_ready, mem_resp_valid, fwd_valid, fwd_address, fwd_size,
        input  commit_ready, misaligned, mem_req_valid, mem_req_address, mem_req_data,
               mem_req_byte_mask, fwd_hit, fwd_data, fwd_conflict, count, empty, trace_rob_tag
    );
endinterface

// File: rtl/committed_store_buffer.sv
// committed_store_buffer: in-order drain of committed stores to L1 with coalescing and load forwarding
module committed_store_buffer #(
    parameter int XLEN            = 32,
    parameter int DEPTH           = 8,
    parameter int ROB_TAG_WIDTH   = 5,
    parameter int MAX_OUTSTANDING = 2,
    parameter int COALESCE        = 1
) (
    input logic clk,
    input logic reset,
    committed_store_buffer_if.slave sb
);
    localparam int NB  = XLEN / 8;
    localparam int OFF = $clog2(NB);
    localparam int AW  = $clog2(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] MAXO = (AW+1)'(MAX_OUTSTANDING);
    typedef enum logic [1:0] {FREE, PENDING, ISSUED} state_e;
    state_e                   state_q [DEPTH];
    logic [XLEN-1:0]          addr_q  [DEPTH];
    logic [XLEN-1:0]          data_q  [DEPTH];
    logic [NB-1:0]            mask_q  [DEPTH];
    logic [ROB_TAG_WIDTH-1:0] tag_q   [DEPTH];
    logic [AW:0]              head_q, issue_q, tail_q, head_d, issue_d, tail_d;
    logic                     misaligned_q;
    logic [AW-1:0]            hd, iss, tl, yg, idx;
    logic                     full, mis, take, coal, wr, req_valid, fire, ack;
    logic [OFF-1:0]           c_off, f_off;
    logic [NB-1:0]            c_mask, f_req, cov;
    logic [2*NB-1:0]          f_wide;
    logic [XLEN-1:0]          c_word, c_data, f_word, src;
    logic                     f_all, f_any;

    function automatic logic [XLEN-1:0] lanes(input logic [NB-1:0] m);
        for (int b = 0; b < NB; b++) lanes[8*b+:8] = {8{m[b]}};
    endfunction

    function automatic logic [NB-1:0] size_mask(input logic [1:0] s);
        return NB'(s == 2'd0 ? 8'h01 : s == 2'd1 ? 8'h03 : s == 2'd2 ? 8'h0F : 8'hFF);
    endfunction

    function automatic logic [XLEN-1:0] word_of(input logic [XLEN-1:0] a);
        return {a[XLEN-1:OFF], {OFF{1'b0}}};
    endfunction

    // commit decode, coalesce/issue/ack decisions and pointer next-state
    always_comb begin
        hd        = head_q[AW-1:0];
        iss       = issue_q[AW-1:0];
        tl        = tail_q[AW-1:0];
        yg        = tl - AW'(1);
        full      = hd == tl && head_q[AW] != tail_q[AW];
        c_off     = sb.commit_address[OFF-1:0];
        c_word    = word_of(sb.commit_address);
        c_mask    = size_mask(sb.commit_size) << c_off;
        c_data    = (sb.commit_data << {c_off, 3'b000}) & lanes(c_mask);
        mis       = (sb.commit_size == 2'd1 && sb.commit_address[0]) ||
                    (sb.commit_size == 2'd2 && sb.commit_address[1:0] != 2'd0) ||
                    (sb.commit_size == 2'd3 && (XLEN == 32 || sb.commit_address[2:0] != 3'd0));
        take      = sb.commit_valid && !full && !mis;
        coal      = COALESCE != 0 && take && state_q[yg] == PENDING && yg != iss && addr_q[yg] == c_word;
        wr        = take && !coal;
        req_valid = state_q[iss] == PENDING && (issue_q - head_q) < MAXO;
        fire      = req_valid && sb.mem_req_ready;
        ack       = sb.mem_resp_valid && state_q[hd] == ISSUED;
        head_d    = ack ? head_q + ONE : head_q;
        issue_d   = fire ? issue_q + ONE : issue_q;
        tail_d    = wr ? tail_q + ONE : tail_q;
    end

    // entry lifecycle and pointers; reset abandons everything including in-flight requests
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) state_q[i] <= FREE;
            head_q       <= '0;
            issue_q      <= '0;
            tail_q       <= '0;
            misaligned_q <= 1'b0;
        end else begin
            if (ack) state_q[hd] <= FREE;
            if (fire) state_q[iss] <= ISSUED;
            if (wr) state_q[tl] <= PENDING;
            head_q       <= head_d;
            issue_q      <= issue_d;
            tail_q       <= tail_d;
            misaligned_q <= sb.commit_valid && !full && mis;
        end
    end

    // entry payload: fresh write at tail or byte-lane merge into the youngest pending entry
    always_ff @(posedge clk) begin
        if (wr) begin
            addr_q[tl] <= c_word;
            data_q[tl] <= c_data;
            mask_q[tl] <= c_mask;
            tag_q[tl]  <= sb.commit_rob_tag;
        end else if (coal) begin
            data_q[yg] <= (data_q[yg] & ~lanes(c_mask)) | c_data;
            mask_q[yg] <= mask_q[yg] | c_mask;
            tag_q[yg]  <= sb.commit_rob_tag;
        end
    end

    // forwarding: walk oldest to youngest so the youngest covering entry wins each byte
    always_comb begin
        f_off  = sb.fwd_address[OFF-1:0];
        f_word = word_of(sb.fwd_address);
        f_wide = {{NB{1'b0}}, size_mask(sb.fwd_size)} << f_off;
        f_req  = f_wide[NB-1:0];
        cov    = '0;
        src    = '0;
        idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = hd + AW'(i);
            if (state_q[idx] != FREE && addr_q[idx] == f_word)
                for (int b = 0; b < NB; b++)
                    if (mask_q[idx][b]) begin
                        cov[b]       = 1'b1;
                        src[8*b+:8]  = data_q[idx][8*b+:8];
                    end
        end
        f_all = f_wide[2*NB-1:NB] == '0 && (f_req & ~cov) == '0;
        f_any = (f_req & cov) != '0;
    end

    assign sb.commit_ready      = !full;
    assign sb.misaligned        = misaligned_q;
    assign sb.mem_req_valid     = req_valid;
    assign sb.mem_req_address   = addr_q[iss];
    assign sb.mem_req_data      = data_q[iss];
    assign sb.mem_req_byte_mask = mask_q[iss];
    assign sb.fwd_hit           = sb.fwd_valid && f_all;
    assign sb.fwd_conflict      = sb.fwd_valid && f_any && !f_all;
    assign sb.fwd_data          = (sb.fwd_valid && f_all) ? (src >> {f_off, 3'b000}) & lanes(size_mask(sb.fwd_size)) : '0;
    assign sb.count             = tail_q - head_q;
    assign sb.empty             = tail_q == head_q;
    assign sb.trace_rob_tag     = tag_q[hd];
endmodule

// File: tb/tb_committed_store_buffer.sv
// tb_committed_store_buffer: scoreboard-checked bench for the committed store buffer
module tb_committed_store_buffer;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } req_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail = 0;
    int   fires = 0;
    int   mcount = 0;
    int   mout = 0;
    logic m_mis = 1'b0;
    req_t q[$];

    always #5 clk = ~clk;

    committed_store_buffer_if #(.XLEN(32), .ROB_TAG_WIDTH(5), .DEPTH(8)) sb();

    committed_store_buffer #(
        .XLEN(32), .DEPTH(8), .ROB_TAG_WIDTH(5), .MAX_OUTSTANDING(2), .COALESCE(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sb(sb)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] lanes4(input logic [3:0] m);
        for (int b = 0; b < 4; b++) lanes4[8*b+:8] = {8{m[b]}};
    endfunction

    function automatic logic [3:0] smask(input logic [1:0] s);
        return s == 2'd0 ? 4'h1 : s == 2'd1 ? 4'h3 : 4'hF;
    endfunction

    // compare outputs against the model just before the edge, then advance the model
    task automatic tick();
        logic [31:0] a, d, w;
        logic [3:0]  m;
        logic        mis, acc, coal, exp_v;
        int          li;
        req_t        t;
        #1;
        exp_v = q.size() > 0 && mout < 2;
        check("req_valid", sb.mem_req_valid, exp_v);
        if (exp_v && sb.mem_req_valid) begin
            check("req_addr", sb.mem_req_address, q[0].a);
            check("req_data", sb.mem_req_data, q[0].d);
            check("req_mask", sb.mem_req_byte_mask, q[0].m);
        end
        check("commit_ready", sb.commit_ready, mcount < 8);
        check("count", sb.count, mcount);
        check("empty", sb.empty, mcount == 0);
        check("misaligned", sb.misaligned, m_mis);
        a    = sb.commit_address;
        w    = {a[31:2], 2'b00};
        m    = smask(sb.commit_size) << a[1:0];
        d    = (sb.commit_data << (8 * a[1:0])) & lanes4(m);
        mis  = (sb.commit_size == 2'd1 && a[0]) || (sb.commit_size == 2'd2 && a[1:0] != 2'd0) ||
               sb.commit_size == 2'd3;
        acc  = sb.commit_valid && mcount < 8;
        coal = acc && !mis && q.size() >= 2 && q[q.size()-1].a == w;
        if (exp_v && sb.mem_req_ready) begin
            void'(q.pop_front());
            mout++;
            fires++;
        end
        if (sb.mem_resp_valid && mout > 0) begin
            mout--;
            mcount--;
        end
        if (acc && !mis) begin
            if (coal) begin
                li  = q.size() - 1;
                t   = q[li];
                t.d = (t.d & ~lanes4(m)) | d;
                t.m = t.m | m;
                q[li] = t;
            end else begin
                q.push_back('{a: w, d: d, m: m});
                mcount++;
            end
        end
        m_mis = acc && mis;
        if (reset) begin
            q.delete();
            mcount = 0;
            mout   = 0;
            m_mis  = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic commit(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        sb.commit_valid   = 1'b1;
        sb.commit_address = a;
        sb.commit_data    = d;
        sb.commit_size    = s;
        sb.commit_rob_tag = a[6:2];
        tick();
        sb.commit_valid = 1'b0;
    endtask

    task automatic fwd(input string tag, input logic [31:0] a, input logic [1:0] s,
                       input logic hit, input logic conf, input logic [31:0] data);
        sb.fwd_valid   = 1'b1;
        sb.fwd_address = a;
        sb.fwd_size    = s;
        #1;
        check({tag, "_hit"}, sb.fwd_hit, hit);
        check({tag, "_conflict"}, sb.fwd_conflict, conf);
        check({tag, "_data"}, sb.fwd_data, data);
        sb.fwd_valid = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        sb.commit_valid   = 1'b0;
        sb.commit_address = '0;
        sb.commit_data    = '0;
        sb.commit_size    = '0;
        sb.commit_rob_tag = '0;
        sb.mem_req_ready  = 1'b0;
        sb.mem_resp_valid = 1'b0;
        sb.fwd_valid      = 1'b0;
        sb.fwd_address    = '0;
        sb.fwd_size       = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tick();
        fwd("rst_fwd", 32'h100, 2'd2, 1'b0, 1'b0, 32'h0);

        sb.mem_req_ready = 1'b1;
        commit(32'h100, 32'hDEADBEEF, 2'd2);
        tick();
        check("t1_fired", fires, 1);
        sb.mem_resp_valid = 1'b1;
        tick();
        sb.mem_resp_valid = 1'b0;
        tick();
        check("t1_empty", sb.empty, 1'b1);

        sb.mem_req_ready = 1'b0;
        commit(32'h500, 32'h12345678, 2'd2);
        commit(32'h203, 32'hAA, 2'd0);
        commit(32'h201, 32'h55, 2'd0);
        check("t2_count", sb.count, 2);
        sb.mem_req_ready = 1'b1;
        tick();
        check("t2_addr", sb.mem_req_address, 32'h200);
        check("t2_mask", sb.mem_req_byte_mask, 4'b1010);
        check("t2_data", sb.mem_req_data, 32'hAA005500);
        tick();
        sb.mem_resp_valid = 1'b1;
        repeat (3) tick();
        sb.mem_resp_valid = 1'b0;
        tick();

        sb.mem_req_ready = 1'b0;
        for (int i = 0; i < 8; i++) commit(32'h1000 + 32'(16 * i), 32'(i), 2'd2);
        check("t3_count_full", sb.count, 8);
        check("t3_ready_low", sb.commit_ready, 1'b0);
        commit(32'h1070, 32'hFF, 2'd0);
        check("t3_full_refused", sb.count, 8);
        fires = 0;
        sb.mem_req_ready = 1'b1;
        repeat (4) tick();
        check("t3_two_issued", fires, 2);
        check("t3_valid_drop", sb.mem_req_valid, 1'b0);
        sb.mem_resp_valid = 1'b1;
        tick();
        sb.mem_resp_valid = 1'b0;
        tick();
        check("t3_third_issued", fires, 3);
        sb.mem_resp_valid = 1'b1;
        repeat (14) tick();
        sb.mem_resp_valid = 1'b0;
        tick();
        check("t3_drained", sb.empty, 1'b1);

        sb.mem_req_ready = 1'b0;
        commit(32'h300, 32'h11223344, 2'd2);
        fwd("t4_w300", 32'h300, 2'd2, 1'b1, 1'b0, 32'h11223344);
        fwd("t4_h302", 32'h302, 2'd1, 1'b1, 1'b0, 32'h1122);
        fwd("t4_w304", 32'h304, 2'd2, 1'b0, 1'b0, 32'h0);

        commit(32'h401, 32'h77, 2'd0);
        fwd("t5_w400", 32'h400, 2'd2, 1'b0, 1'b1, 32'h0);
        fwd("t5_b401", 32'h401, 2'd0, 1'b1, 1'b0, 32'h77);
        commit(32'h300, 32'h99, 2'd0);
        fwd("t5_young", 32'h300, 2'd2, 1'b1, 1'b0, 32'h11223399);
        commit(32'h401, 32'h1234, 2'd1);
        check("t5_mis_pulse", sb.misaligned, 1'b1);
        check("t5_mis_count", sb.count, 3);
        tick();
        check("t5_mis_clear", sb.misaligned, 1'b0);

        sb.mem_req_ready = 1'b1;
        repeat (2) tick();
        sb.mem_req_ready = 1'b0;
        commit(32'h600, 32'h66, 2'd2);
        commit(32'h700, 32'h77, 2'd2);
        check("t6_count_pre", sb.count, 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_empty", sb.empty, 1'b1);
        check("t6_req_valid", sb.mem_req_valid, 1'b0);
        sb.mem_resp_valid = 1'b1;
        tick();
        sb.mem_resp_valid = 1'b0;
        check("t6_stray_ack", sb.count, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
